// File: rtl/ysyx_22041752_msu.sv
// Memory stage: holds one instruction, selects and extends load data; results appear combinationally (non-load the cycle after capture, load in its rvalid cycle).
// Backpressure: a load stalls until rvalid; rvalid data is buffered in HOLD while writeback refuses.
module ysyx_22041752_msu (
  input  logic         clk,
  input  logic         reset,
  input  logic         es_to_ms_valid,
  input  logic [138:0] es_to_ms_bus,
  output logic         ms_allowin,
  input  logic         data_sram_rvalid,
  input  logic [63:0]  data_sram_rdata,
  input  logic         ws_allowin,
  output logic         ms_to_ws_valid,
  output logic [133:0] ms_to_ws_bus,
  output logic [70:0]  ms_forward_bus,
  output logic [63:0]  debug_ms_pc
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t       state;
  logic         ms_valid;
  logic [138:0] ms_bus_r;
  logic [63:0]  hold_buf;

  logic         res_zext;
  logic [1:0]   mem_bytes;
  logic         mem_re;
  logic         rf_we;
  logic [4:0]   rd;
  logic [63:0]  alu_result;
  logic [63:0]  pc;
  logic         unused_res_sext;

  assign unused_res_sext = ms_bus_r[138];
  assign res_zext        = ms_bus_r[137];
  assign mem_bytes       = ms_bus_r[136:135];
  assign mem_re          = ms_bus_r[134];
  assign rf_we           = ms_bus_r[133];
  assign rd              = ms_bus_r[132:128];
  assign alu_result      = ms_bus_r[127:64];
  assign pc              = ms_bus_r[63:0];

  logic        ms_ready_go;
  logic [63:0] src;
  logic [2:0]  off;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;
  logic [63:0] load_res;
  logic [63:0] ms_final_result;
  logic        load_pending;
  logic        fwd_valid;

  assign ms_ready_go    = !mem_re || (state == WAIT && data_sram_rvalid) || state == HOLD;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // Misaligned accesses are not trapped; the upper offset bits pick the aligned lane.
  assign src    = (state == HOLD) ? hold_buf : data_sram_rdata;
  assign off    = alu_result[2:0];
  assign byte_v = src[{off, 3'b000} +: 8];
  assign half_v = src[{off[2:1], 4'b0000} +: 16];
  assign word_v = src[{off[2], 5'b00000} +: 32];

  always_comb begin
    load_res = src;
    case (mem_bytes)
      2'b00:   load_res = res_zext ? {56'd0, byte_v} : {{56{byte_v[7]}}, byte_v};
      2'b01:   load_res = res_zext ? {48'd0, half_v} : {{48{half_v[15]}}, half_v};
      2'b10:   load_res = res_zext ? {32'd0, word_v} : {{32{word_v[31]}}, word_v};
      default: load_res = src;
    endcase
  end

  assign ms_final_result = mem_re ? load_res : alu_result;
  assign load_pending    = ms_valid && mem_re && !ms_ready_go;
  assign fwd_valid       = ms_valid && rf_we;

  assign ms_to_ws_bus   = {rf_we, rd, ms_final_result, pc};
  assign ms_forward_bus = {load_pending, fwd_valid, ms_final_result, rd};
  assign debug_ms_pc    = pc;

  // Payload is only meaningful while ms_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin)
      ms_bus_r <= es_to_ms_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      state    <= IDLE;
      hold_buf <= 64'd0;
    end else begin
      if (ms_allowin)
        ms_valid <= es_to_ms_valid;

      // A newly accepted load wins over the departing instruction's transition.
      if (ms_allowin && es_to_ms_valid && es_to_ms_bus[134]) begin
        state <= WAIT;
      end else begin
        case (state)
          WAIT:    if (data_sram_rvalid) state <= ws_allowin ? IDLE : HOLD;
          HOLD:    if (ws_allowin) state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (state == WAIT && data_sram_rvalid)
        hold_buf <= data_sram_rdata;
    end
  end

endmodule
